// File: rtl/fb_ram_port_arb_if.sv
// Bus bundle between the frame-buffer RAM port arbiter, its two clients and the RAM pins.
// Handshake: a transfer happens on a rising edge where valid and ready are both high; valid never waits on ready.
interface fb_ram_port_arb_if #(
    parameter int DW = 8,
    parameter int AW = 12
) ();
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    logic          rd_req_valid;
    logic          rd_req_ready;
    logic [AW-1:0] rd_req_addr;

    logic          rd_rsp_valid;
    logic          rd_rsp_ready;
    logic [DW-1:0] rd_rsp_data;

    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wr;
    logic          ram_we;
    logic [DW-1:0] ram_rd;

    // Observation points: buffer occupancy, read in flight at the RAM, last grant was a read.
    logic [1:0]    dbg_count;
    logic          dbg_inflight;
    logic          dbg_last_grant_rd;

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        input  rd_req_valid, rd_req_addr, rd_rsp_ready,
        input  ram_rd,
        output wr_ready, rd_req_ready, rd_rsp_valid, rd_rsp_data,
        output ram_addr, ram_wr, ram_we,
        output dbg_count, dbg_inflight, dbg_last_grant_rd
    );

    modport master (
        output wr_valid, wr_addr, wr_data,
        output rd_req_valid, rd_req_addr, rd_rsp_ready,
        output ram_rd,
        input  wr_ready, rd_req_ready, rd_rsp_valid, rd_rsp_data,
        input  ram_addr, ram_wr, ram_we,
        input  dbg_count, dbg_inflight, dbg_last_grant_rd
    );
endinterface

// File: rtl/fb_ram_port_arb.sv
// Two-client (capture write / display read) arbiter owning the single-port frame-buffer RAM pins.
// Macro FB_ARB_RR_EN selects round-robin conflict resolution; undefined gives write priority.
module fb_ram_port_arb #(
    parameter int DW = 8,
    parameter int AW = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    fb_ram_port_arb_if.slave bus
);

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_e;

    grant_e        last_grant_q, last_grant_d;
    logic [1:0]    count_q, count_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic          inflight_q, inflight_d;
    logic [DW-1:0] buf_q [2];
    logic [DW-1:0] buf_d [2];

    logic          pop;
    logic          push;
    logic [1:0]    credit_used;
    logic          rd_ok;
    logic          write_wins;
    logic          gw;
    logic          gr;
    logic [AW-1:0] ram_addr_c;
    logic [DW-1:0] ram_wr_c;

    always_comb begin
        pop  = (count_q != 2'd0) && bus.rd_rsp_ready;
        push = inflight_q;
        // Credit counts the in-flight read and is recovered by a pop in the same cycle,
        // which lets reads stream one per cycle while the consumer keeps up.
        credit_used = count_q + {1'b0, inflight_q} - {1'b0, pop};
        rd_ok       = credit_used < 2'd2;
`ifdef FB_ARB_RR_EN
        write_wins = (last_grant_q == GRANT_RD);
`else
        write_wins = 1'b1;
`endif
        gw = bus.wr_valid && (!bus.rd_req_valid || !rd_ok || write_wins);
        gr = bus.rd_req_valid && rd_ok && !gw;

        // Idle cycles drive zeros with we=0; the RAM's dummy read result is never captured.
        ram_addr_c = '0;
        ram_wr_c   = '0;
        if (gw) begin
            ram_addr_c = bus.wr_addr;
            ram_wr_c   = bus.wr_data;
        end else if (gr) begin
            ram_addr_c = bus.rd_req_addr;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        inflight_d   = gr;
        count_d      = count_q + {1'b0, push} - {1'b0, pop};
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        buf_d        = buf_q;

        if (gw) begin
            last_grant_d = GRANT_WR;
        end else if (gr) begin
            last_grant_d = GRANT_RD;
        end

        // ram_rd is valid exactly one cycle after the read grant, i.e. while inflight_q is set.
        if (push) begin
            buf_d[wr_ptr_q] = bus.ram_rd;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GRANT_WR;
            count_q      <= 2'd0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            inflight_q   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            last_grant_q <= last_grant_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            inflight_q   <= inflight_d;
            for (int i = 0; i < 2; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    assign bus.wr_ready          = gw;
    assign bus.rd_req_ready      = gr;
    assign bus.rd_rsp_valid      = (count_q != 2'd0);
    assign bus.rd_rsp_data       = buf_q[rd_ptr_q];
    assign bus.ram_we            = gw;
    assign bus.ram_addr          = ram_addr_c;
    assign bus.ram_wr            = ram_wr_c;
    assign bus.dbg_count         = count_q;
    assign bus.dbg_inflight      = inflight_q;
    assign bus.dbg_last_grant_rd = (last_grant_q == GRANT_RD);

endmodule

// File: tb/tb_fb_ram_port_arb.sv
// Bench for fb_ram_port_arb: behavioural RAM, queue-based reference model, directed and random scenarios.
module tb_fb_ram_port_arb;
    localparam int DW = 8;
    localparam int AW = 12;
    localparam int MEM_N = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fb_ram_port_arb_if #(.DW(DW), .AW(AW)) bus ();

    fb_ram_port_arb #(.DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Single-port RAM: registered read, read port holds during a write.
    logic [DW-1:0] ram_mem [MEM_N];
    logic [DW-1:0] ram_rd_q = '0;
    always @(posedge clk) begin
        if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wr;
        else            ram_rd_q <= ram_mem[bus.ram_addr];
    end
    assign bus.ram_rd = ram_rd_q;

    // Reference model: memory image, outstanding read responses in order with the cycle each becomes visible.
    logic [DW-1:0] shadow [MEM_N];
    logic [DW-1:0] exp_q [$];
    int            due_q [$];
    int            cyc;
    bit            last_rd;
    int            n_cmp = 0;
    int            n_err = 0;

    logic          e_gw, e_gr, e_rv, e_pop;
    logic [DW-1:0] e_data;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wr;

    task automatic set_in(input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                          input bit rv, input logic [AW-1:0] ra, input bit rr);
        bus.wr_valid     = wv;
        bus.wr_addr      = wa;
        bus.wr_data      = wd;
        bus.rd_req_valid = rv;
        bus.rd_req_addr  = ra;
        bus.rd_rsp_ready = rr;
    endtask

    task automatic model_eval();
        bit rd_can;
        int held;
        e_rv   = (exp_q.size() > 0) && (due_q[0] <= cyc);
        e_data = e_rv ? exp_q[0] : '0;
        e_pop  = e_rv && bus.rd_rsp_ready;
        held   = exp_q.size() - (e_pop ? 1 : 0);
        rd_can = bus.rd_req_valid && (held < 2);
        if (bus.wr_valid && rd_can) begin
`ifdef FB_ARB_RR_EN
            e_gr = !last_rd;
`else
            e_gr = 1'b0;
`endif
            e_gw = !e_gr;
        end else begin
            e_gw = bus.wr_valid;
            e_gr = rd_can;
        end
        e_addr = e_gw ? bus.wr_addr : (e_gr ? bus.rd_req_addr : '0);
        e_wr   = e_gw ? bus.wr_data : '0;
    endtask

    task automatic tick();
        if (e_pop) begin
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
        end
        if (e_gr) begin
            exp_q.push_back(shadow[bus.rd_req_addr]);
            due_q.push_back(cyc + 2);
            last_rd = 1'b1;
        end
        if (e_gw) begin
            shadow[bus.wr_addr] = bus.wr_data;
            last_rd = 1'b0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(0, '0, '0, 0, '0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        due_q.delete();
        last_rd = 1'b0;
        cyc = 0;
        rst_n = 1'b1;
    endtask

    // A buffer push while full would mean the credit rule failed.
    always @(negedge clk) begin
        if (rst_n) begin
            n_cmp++;
            if (bus.dbg_count > 2'd2 ||
                (bus.dbg_count == 2'd2 && bus.dbg_inflight && !(bus.rd_rsp_valid && bus.rd_rsp_ready))) begin
                n_err++;
                $display("FAIL overflow t=%0t: count=%0d inflight=%b, required no push into a full buffer",
                         $time, bus.dbg_count, bus.dbg_inflight);
            end
        end
    end

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 2; c++) begin
            set_in(0, '0, '0, 1, 12'h100, 0);
            @(negedge clk);
            model_eval();
            n_cmp++;
            if (bus.wr_ready !== e_gw || bus.rd_req_ready !== e_gr || bus.rd_rsp_valid !== e_rv ||
                bus.ram_we !== e_gw || bus.ram_addr !== e_addr || bus.ram_wr !== e_wr ||
                (e_rv && bus.rd_rsp_data !== e_data)) begin
                n_err++;
                $display("FAIL reset_pre c=%0d: got %b %b %b %h %b %h %h; want %b %b %b %h %b %h %h", c,
                         bus.wr_ready, bus.rd_req_ready, bus.rd_rsp_valid, bus.rd_rsp_data, bus.ram_we, bus.ram_addr, bus.ram_wr,
                         e_gw, e_gr, e_rv, e_data, e_gw, e_addr, e_wr);
            end
            tick();
        end
        n_cmp++;
        if (bus.dbg_count !== 2'd1 || bus.dbg_inflight !== 1'b1) begin
            n_err++;
            $display("FAIL reset_setup: count=%0d inflight=%b, want 1 1", bus.dbg_count, bus.dbg_inflight);
        end
        set_in(0, '0, '0, 0, '0, 1);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.rd_rsp_valid !== 1'b0 || bus.ram_we !== 1'b0 || bus.dbg_count !== 2'd0 || bus.dbg_inflight !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: rsp_v=%b we=%b count=%0d inflight=%b, want 0 0 0 0",
                     bus.rd_rsp_valid, bus.ram_we, bus.dbg_count, bus.dbg_inflight);
        end
        do_reset();
        for (int c = 0; c < 4; c++) begin
            set_in(0, '0, '0, 0, '0, 1);
            @(negedge clk);
            model_eval();
            n_cmp++;
            if (bus.rd_rsp_valid !== 1'b0 || bus.ram_we !== 1'b0 || bus.dbg_last_grant_rd !== 1'b0) begin
                n_err++;
                $display("FAIL reset_after c=%0d: rsp_v=%b we=%b last_rd=%b, want 0 0 0",
                         c, bus.rd_rsp_valid, bus.ram_we, bus.dbg_last_grant_rd);
            end
            tick();
        end
    endtask

    task automatic test_write_read();
        for (int c = 0; c < 4; c++) begin
            set_in(c == 0, 12'h005, 8'hA7, c == 1, 12'h005, 1);
            @(negedge clk);
            model_eval();
            n_cmp++;
            if (bus.wr_ready !== e_gw || bus.rd_req_ready !== e_gr || bus.rd_rsp_valid !== e_rv ||
                bus.ram_we !== e_gw || bus.ram_addr !== e_addr || bus.ram_wr !== e_wr ||
                (e_rv && bus.rd_rsp_data !== e_data)) begin
                n_err++;
                $display("FAIL write_read c=%0d: got %b %b %b %h %b %h %h; want %b %b %b %h %b %h %h", c,
                         bus.wr_ready, bus.rd_req_ready, bus.rd_rsp_valid, bus.rd_rsp_data, bus.ram_we, bus.ram_addr, bus.ram_wr,
                         e_gw, e_gr, e_rv, e_data, e_gw, e_addr, e_wr);
            end
            if (c >= 2) begin
                n_cmp++;
                if (bus.rd_rsp_valid !== (c == 3) || (c == 3 && bus.rd_rsp_data !== 8'hA7)) begin
                    n_err++;
                    $display("FAIL write_read_lat c=%0d: rsp_v=%b data=%h, want %b a7", c, bus.rd_rsp_valid,
                             bus.rd_rsp_data, c == 3);
                end
            end
            tick();
        end
    endtask

    task automatic test_stream();
        int k = 0;
        for (int c = 0; c < 20; c++) begin
            set_in(c < 8, 12'h010 + 12'(c), 8'h10 + 8'(c), c >= 8 && c < 16, 12'h010 + 12'(c - 8), 1);
            @(negedge clk);
            model_eval();
            n_cmp++;
            if (bus.wr_ready !== e_gw || bus.rd_req_ready !== e_gr || bus.rd_rsp_valid !== e_rv ||
                bus.ram_we !== e_gw || bus.ram_addr !== e_addr || bus.ram_wr !== e_wr ||
                (e_rv && bus.rd_rsp_data !== e_data)) begin
                n_err++;
                $display("FAIL stream c=%0d: got %b %b %b %h %b %h %h; want %b %b %b %h %b %h %h", c,
                         bus.wr_ready, bus.rd_req_ready, bus.rd_rsp_valid, bus.rd_rsp_data, bus.ram_we, bus.ram_addr, bus.ram_wr,
                         e_gw, e_gr, e_rv, e_data, e_gw, e_addr, e_wr);
            end
            if (c >= 8 && c < 16) begin
                n_cmp++;
                if (bus.rd_req_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL stream_b2b c=%0d: rd_req_ready=%b, want 1", c, bus.rd_req_ready);
                end
            end
            if (bus.rd_rsp_valid === 1'b1) begin
                n_cmp++;
                if (bus.rd_rsp_data !== 8'h10 + 8'(k)) begin
                    n_err++;
                    $display("FAIL stream_order k=%0d: data=%h, want %h", k, bus.rd_rsp_data, 8'h10 + 8'(k));
                end
                k++;
            end
            tick();
        end
        n_cmp++;
        if (k != 8) begin
            n_err++;
            $display("FAIL stream_count: responses=%0d, want 8", k);
        end
    endtask

    task automatic test_backpressure();
        int issued = 0;
        int k = 0;
        for (int c = 0; c < 16; c++) begin
            set_in(0, '0, '0, issued < 4, 12'h010 + 12'(issued), c >= 4);
            @(negedge clk);
            model_eval();
            n_cmp++;
            if (bus.wr_ready !== e_gw || bus.rd_req_ready !== e_gr || bus.rd_rsp_valid !== e_rv ||
                bus.ram_we !== e_gw || bus.ram_addr !== e_addr || bus.ram_wr !== e_wr ||
                (e_rv && bus.rd_rsp_data !== e_data)) begin
                n_err++;
                $display("FAIL backpressure c=%0d: got %b %b %b %h %b %h %h; want %b %b %b %h %b %h %h", c,
                         bus.wr_ready, bus.rd_req_ready, bus.rd_rsp_valid, bus.rd_rsp_data, bus.ram_we, bus.ram_addr, bus.ram_wr,
                         e_gw, e_gr, e_rv, e_data, e_gw, e_addr, e_wr);
            end
            if (c == 3) begin
                n_cmp++;
                if (issued != 2 || bus.rd_req_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL backpressure_stall: granted=%0d rd_req_ready=%b, want 2 0", issued, bus.rd_req_ready);
                end
            end
            if (bus.rd_rsp_valid === 1'b1 && bus.rd_rsp_ready === 1'b1) begin
                n_cmp++;
                if (bus.rd_rsp_data !== 8'h10 + 8'(k)) begin
                    n_err++;
                    $display("FAIL backpressure_order k=%0d: data=%h, want %h", k, bus.rd_rsp_data, 8'h10 + 8'(k));
                end
                k++;
            end
            if (bus.rd_req_ready === 1'b1) issued++;
            tick();
        end
        n_cmp++;
        if (issued != 4 || k != 4) begin
            n_err++;
            $display("FAIL backpressure_total: granted=%0d returned=%0d, want 4 4", issued, k);
        end
    endtask

    task automatic test_conflict();
        bit [5:0] pat;
        int wn = 0;
`ifdef FB_ARB_RR_EN
        pat = 6'b101010;
`else
        pat = 6'b111111;
`endif
        do_reset();
        for (int c = 0; c < 10; c++) begin
            set_in(c < 6, 12'h200 + 12'(wn), 8'($urandom_range(0, 255)), c < 6, 12'h010, 1);
            @(negedge clk);
            model_eval();
            n_cmp++;
            if (bus.wr_ready !== e_gw || bus.rd_req_ready !== e_gr || bus.rd_rsp_valid !== e_rv ||
                bus.ram_we !== e_gw || bus.ram_addr !== e_addr || bus.ram_wr !== e_wr ||
                (e_rv && bus.rd_rsp_data !== e_data)) begin
                n_err++;
                $display("FAIL conflict c=%0d: got %b %b %b %h %b %h %h; want %b %b %b %h %b %h %h", c,
                         bus.wr_ready, bus.rd_req_ready, bus.rd_rsp_valid, bus.rd_rsp_data, bus.ram_we, bus.ram_addr, bus.ram_wr,
                         e_gw, e_gr, e_rv, e_data, e_gw, e_addr, e_wr);
            end
            if (c < 6) begin
                n_cmp++;
                if (bus.wr_ready !== pat[c] || bus.rd_req_ready !== !pat[c]) begin
                    n_err++;
                    $display("FAIL conflict_pattern c=%0d: wr_ready=%b rd_req_ready=%b, want %b %b",
                             c, bus.wr_ready, bus.rd_req_ready, pat[c], !pat[c]);
                end
            end
            if (bus.wr_ready === 1'b1) wn++;
            tick();
        end
    endtask

    task automatic test_credit_block();
        for (int c = 0; c < 12; c++) begin
            set_in(c >= 2 && c < 6, 12'h300 + 12'(c), 8'hC0 + 8'(c), (c < 2) || (c >= 3 && c < 6), 12'h010 + 12'(c), c >= 6);
            @(negedge clk);
            model_eval();
            n_cmp++;
            if (bus.wr_ready !== e_gw || bus.rd_req_ready !== e_gr || bus.rd_rsp_valid !== e_rv ||
                bus.ram_we !== e_gw || bus.ram_addr !== e_addr || bus.ram_wr !== e_wr ||
                (e_rv && bus.rd_rsp_data !== e_data)) begin
                n_err++;
                $display("FAIL credit_block c=%0d: got %b %b %b %h %b %h %h; want %b %b %b %h %b %h %h", c,
                         bus.wr_ready, bus.rd_req_ready, bus.rd_rsp_valid, bus.rd_rsp_data, bus.ram_we, bus.ram_addr, bus.ram_wr,
                         e_gw, e_gr, e_rv, e_data, e_gw, e_addr, e_wr);
            end
            if (c >= 3 && c < 6) begin
                n_cmp++;
                if (bus.wr_ready !== 1'b1 || bus.ram_we !== 1'b1 || bus.rd_req_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL credit_write_wins c=%0d: wr_ready=%b we=%b rd_req_ready=%b, want 1 1 0",
                             c, bus.wr_ready, bus.ram_we, bus.rd_req_ready);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 520; c++) begin
            bit act;
            act = (c < 500);
            set_in(act && ($urandom_range(0, 1) == 1), 12'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                   act && ($urandom_range(0, 2) != 0), 12'($urandom_range(0, 15)),
                   !act || ($urandom_range(0, 3) != 0));
            @(negedge clk);
            model_eval();
            n_cmp++;
            if (bus.wr_ready !== e_gw || bus.rd_req_ready !== e_gr || bus.rd_rsp_valid !== e_rv ||
                bus.ram_we !== e_gw || bus.ram_addr !== e_addr || bus.ram_wr !== e_wr ||
                (e_rv && bus.rd_rsp_data !== e_data)) begin
                n_err++;
                $display("FAIL random c=%0d: got %b %b %b %h %b %h %h; want %b %b %b %h %b %h %h", c,
                         bus.wr_ready, bus.rd_req_ready, bus.rd_rsp_valid, bus.rd_rsp_data, bus.ram_we, bus.ram_addr, bus.ram_wr,
                         e_gw, e_gr, e_rv, e_data, e_gw, e_addr, e_wr);
            end
            tick();
        end
        n_cmp++;
        if (exp_q.size() != 0 || bus.rd_rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL random_drain: model pending=%0d rsp_v=%b, want 0 0", exp_q.size(), bus.rd_rsp_valid);
        end
    endtask

    initial begin
        for (int i = 0; i < MEM_N; i++) begin
            ram_mem[i] = '0;
            shadow[i]  = '0;
        end
        last_rd = 1'b0;
        cyc = 0;
        set_in(0, '0, '0, 0, '0, 0);
        test_reset();
        test_write_read();
        test_stream();
        test_backpressure();
        test_conflict();
        test_credit_block();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/fb_ram_port_arb.md
Name: fb_ram_port_arb

Overview:
- Two-client arbiter that sits directly upstream of the single-port frame-buffer RAM (the mu_ram_1rw instance) and owns its addr/wr/we pins.
- Write client is the sensor capture path; it pushes pixels. Read client is the display/colour-map path; it requests pixels.
- Converts the RAM's one-cycle, hold-on-write read behaviour into a valid/ready read-response stream backed by a 2-entry response buffer.
- Grants at most one RAM access per cycle.

Parameters:
- DW, 8, pixel data width; must match the RAM's DW.
- AW, 12, address width; must match the RAM's AW.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  write request pending.
- wr_ready  out  1  write accepted this cycle.
- wr_addr  in  AW  write address.
- wr_data  in  DW  write data.
- rd_req_valid  in  1  read request pending.
- rd_req_ready  out  1  read request accepted this cycle.
- rd_req_addr  in  AW  read address.
- rd_rsp_valid  out  1  read data available.
- rd_rsp_ready  in  1  consumer takes the read data.
- rd_rsp_data  out  DW  read data; returned in request order.
- ram_addr  out  AW  to RAM addr.
- ram_wr  out  DW  to RAM wr.
- ram_we  out  1  to RAM we.
- ram_rd  in  DW  from RAM rd; registered by the RAM, valid 1 cycle after a non-write access.

Behaviour:
- Reset is asynchronous and active-low. Clock port is clk; reset port is rst_n.
- Reset clears:
  - response buffer count, read/write pointers and in-flight flag → rd_rsp_valid=0;
  - RR pointer → last_grant=WRITE, so a read wins the first conflict.
- Reset mid-operation: an in-flight read is discarded; buffered responses are lost.
- Credit: rd_ok = (count + inflight) < 2. Here inflight is a flag set in the cycle after a read grant. Counting it prevents buffer overflow.
- Grant logic is combinational in cycle N:
  - gw = wr_valid and (not rd_req_valid or not rd_ok or write wins arbitration).
  - gr = rd_req_valid and rd_ok and not gw.
- wr_ready=gw, rd_req_ready=gr.
- RAM drive:
  - gw: ram_we=1, ram_addr=wr_addr, ram_wr=wr_data.
  - gr: ram_we=0, ram_addr=rd_req_addr.
  - idle: ram_we=0, ram_addr=0, ram_wr=0. With we=0 the RAM performs a harmless read; the result is ignored.
  - ram_wr=0 whenever gw=0.
- Read pipeline:
  - Grant in cycle N.
  - inflight=1 in N+1; ram_rd is sampled into the buffer at the end of N+1.
  - rd_rsp_valid=1 from N+2. Latency is 2 cycles when the output is not stalled.
- Response buffer:
  - 2-entry FIFO; rd_rsp_data = head entry, registered.
  - Pop when rd_rsp_valid and rd_rsp_ready.
  - Push and pop in the same cycle keeps count unchanged.
  - Pop while empty is ignored.
  - A push while full is impossible by credit rule. The bench asserts this.
- Back-to-back reads: with rd_rsp_ready held high, a read can be granted every cycle. Credit is recovered via the pop in the same cycle (count+inflight evaluated after the current pop).
- Writes never depend on response credit.
- Write-after-read hazard does not exist: requests complete in grant order at the RAM port.
- last_grant updates on every gw/gr to WRITE/READ; it holds when idle.

Optional Feature:
- Macro FB_ARB_RR_EN.
- Defined: round-robin. On conflict (both valid, rd_ok=1), grant the client opposite to last_grant.
- Undefined: fixed priority; write always wins conflicts and last_grant is unused. Sensor capture then never stalls; display may starve while capture streams.

Test Plan:
- Reset: rst_n low mid-read (inflight=1, count=1) → rd_rsp_valid=0 immediately, no stale data after release; ram_we=0.
- Single write then read: write addr 0x005 data 0xA7; read 0x005 → rd_rsp_valid rises 2 cycles after grant, rd_rsp_data=0xA7.
- Streaming reads: 8 consecutive reads of 0x010..0x017 (preloaded 0x10+i) with rd_rsp_ready=1 → rd_req_ready high every cycle, data 0x10..0x17 in order, one per cycle.
- Backpressure: rd_rsp_ready=0, 4 read requests → exactly 2 granted, then rd_req_ready=0. Releasing ready → remaining 2 granted; data order preserved; no overflow assertion.
- Conflict with FB_ARB_RR_EN: both valid for 6 cycles → grants alternate R,W,R,W,R,W. Without the macro → W,W,W,W,W,W and rd_req_ready=0 throughout.
- Credit-blocked read with write pending: buffer full, both valid → write granted (ram_we=1) regardless of RR pointer.
